rx_link_ctrl: RTL

Receive-side link controller for the PHY receive path. It runs on the clk_4f byte clock, consumes the byte stream from the serial-to-parallel deserializer, and acquires and monitors link synchronization with a comma-counting state machine. Once synchronized, it schedules data bytes round-robin across the four output lanes and drives the lane select and valid strobe consumed by the lane demultiplexers. It replaces the bare `active` flag with a sequenced acquire/lock/loss protocol and generates the idle pattern while the link is down.

---
 rtl/rx_link_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/rx_link_ctrl.sv
// Receive link controller: comma-count sync acquisition, gap-based loss detection, round-robin lane scheduling.
// Optional loss-of-sync statistics counter enabled by defining RX_LINK_STATS_EN.
module rx_link_ctrl #(
   parameter logic [7:0] BC_CHAR   = 8'hBC,
   parameter logic [7:0] IDLE_CHAR = 8'h7C,
   parameter int unsigned SYNC_CNT = 4,
   parameter int unsigned GAP_MAX  = 3
) (
   input  logic       clk_4f,
   input  logic       reset_L,
   input  logic [7:0] sp_byte,
   input  logic       sp_valid,
   output logic [7:0] data_out,
   output logic       data_valid,
   output logic [1:0] lane_sel,
   output logic       active,
   output logic [7:0] idle_out,
   output logic [7:0] sync_loss_cnt
);

   typedef enum logic [1:0] {HUNT, SYNCING, LOCKED} state_t;

   localparam logic [3:0] SYNC_CNT_W = 4'(SYNC_CNT);
   localparam logic [3:0] GAP_MAX_W  = 4'(GAP_MAX);
   localparam bit         LOCK_ON_FIRST = (SYNC_CNT == 1);

   state_t     state, state_nx;
   logic [3:0] bc_cnt, bc_nx;
   logic [3:0] gap_cnt, gap_nx;
   logic [1:0] lane_ptr, lane_nx;
   logic [7:0] dout_nx;
   logic [1:0] lsel_nx;
   logic       dv_nx;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_4f) begin
      if (!reset_L) begin
         state      <= HUNT;
         bc_cnt     <= '0;
         gap_cnt    <= '0;
         lane_ptr   <= '0;
         data_out   <= '0;
         data_valid <= 1'b0;
         lane_sel   <= '0;
      end else begin
         state      <= state_nx;
         bc_cnt     <= bc_nx;
         gap_cnt    <= gap_nx;
         lane_ptr   <= lane_nx;
         data_out   <= dout_nx;
         data_valid <= dv_nx;
         lane_sel   <= lsel_nx;
      end
   end

   // NOTE: every combinational output gets a default first so no path can infer a latch.
   always_comb begin
      state_nx = state;
      bc_nx    = bc_cnt;
      gap_nx   = gap_cnt;
      lane_nx  = lane_ptr;
      dout_nx  = data_out;
      lsel_nx  = lane_sel;
      dv_nx    = 1'b0;
      case (state)
         HUNT: begin
            if (sp_valid && sp_byte == BC_CHAR) begin
               bc_nx = 4'd1;
               if (LOCK_ON_FIRST) begin
                  state_nx = LOCKED;
                  lane_nx  = '0;
                  gap_nx   = '0;
               end else begin
                  state_nx = SYNCING;
               end
            end else begin
               bc_nx = '0;
            end
         end
         SYNCING: begin
            if (sp_valid) begin
               if (sp_byte == BC_CHAR) begin
                  bc_nx = bc_cnt + 4'd1;
                  if (bc_nx == SYNC_CNT_W) begin
                     state_nx = LOCKED;
                     lane_nx  = '0;
                     gap_nx   = '0;
                  end
               end else begin
                  state_nx = HUNT;
                  bc_nx    = '0;
               end
            end
         end
         LOCKED: begin
            if (sp_valid) begin
               gap_nx = '0;
               // Comma and idle bytes keep the link alive but carry no payload.
               if (sp_byte != BC_CHAR && sp_byte != IDLE_CHAR) begin
                  dout_nx = sp_byte;
                  lsel_nx = lane_ptr;
                  dv_nx   = 1'b1;
                  lane_nx = lane_ptr + 2'd1;
               end
            end else begin
               gap_nx = (gap_cnt == 4'hF) ? gap_cnt : gap_cnt + 4'd1;
               if (gap_nx == GAP_MAX_W) begin
                  state_nx = HUNT;
                  bc_nx    = '0;
               end
            end
         end
         default: begin
            state_nx = HUNT;
            bc_nx    = '0;
         end
      endcase
   end

   assign active   = (state == LOCKED);
   assign idle_out = active ? 8'h00 : IDLE_CHAR;

`ifdef RX_LINK_STATS_EN
   logic [7:0] loss_q;
   logic       loss_evt;

   assign loss_evt = (state == LOCKED) && (state_nx == HUNT);

   always_ff @(posedge clk_4f) begin
      if (!reset_L)
         loss_q <= '0;
      else if (loss_evt && loss_q != 8'hFF)
         loss_q <= loss_q + 8'd1;
   end

   assign sync_loss_cnt = loss_q;
`else
   assign sync_loss_cnt = 8'h00;
`endif

endmodule
